// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: round constants, S-box lookup, key-schedule state enum.
package aes_pkg;

    localparam int unsigned AES_NR     = 10;
    localparam int unsigned AES_KEY_W  = 128;
    localparam int unsigned AES_WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } aes_state_e;

    // Round key as four 32-bit words, w0 in the most significant position.
    typedef struct packed {
        logic [AES_WORD_W-1:0] w0;
        logic [AES_WORD_W-1:0] w1;
        logic [AES_WORD_W-1:0] w2;
        logic [AES_WORD_W-1:0] w3;
    } aes_rk_t;

    // Index 0 is unused; rounds 1..10 use entries 1..10.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Out-of-range round indices yield zero rather than reading past the table.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        return (r <= 4'd10) ? RCON[r] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: byte-wise AES S-box substitution of one 32-bit word (combinational).
module aes_subword
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] w,
    output logic [AES_WORD_W-1:0] sub_c
);

    assign sub_c[31:24] = sbox(w[31:24]);
    assign sub_c[23:16] = sbox(w[23:16]);
    assign sub_c[15:8]  = sbox(w[15:8]);
    assign sub_c[7:0]   = sbox(w[7:0]);

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per valid/ready beat, rounds 0..10.
// Define AES_KEY_STORE_EN to keep an 11-entry round-key store readable via rd_addr/rd_data.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NR      = 10,
    parameter int unsigned ROUND_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [AES_KEY_W-1:0] key_in,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [ROUND_W-1:0]   rk_round,
    output logic [AES_KEY_W-1:0] rk_data,
    output logic                 busy,
    output logic                 done,
    input  logic [ROUND_W-1:0]   rd_addr,
    output logic [AES_KEY_W-1:0] rd_data
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_schedule: only NR=10 (AES-128) is supported");
    end

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    aes_state_e             state, state_nxt;
    logic                   rk_valid_nxt, done_nxt;
    logic [ROUND_W-1:0]     rk_round_nxt, round_inc;
    logic [AES_KEY_W-1:0]   rk_data_nxt;
    aes_rk_t                cur;
    logic [AES_WORD_W-1:0]  rot_w, sub_w, temp_w;
    logic [AES_WORD_W-1:0]  nw0, nw1, nw2, nw3;

    // Next round key from the one currently on rk_data.
    assign cur       = aes_rk_t'(rk_data);
    assign round_inc = rk_round + ROUND_W'(1);
    assign rot_w     = {cur.w3[23:0], cur.w3[31:24]};

    aes_subword u_subword (
        .w     (rot_w),
        .sub_c (sub_w)
    );

    assign temp_w = sub_w ^ {rcon(4'(round_inc)), 24'h0};
    assign nw0    = cur.w0 ^ temp_w;
    assign nw1    = cur.w1 ^ nw0;
    assign nw2    = cur.w2 ^ nw1;
    assign nw3    = cur.w3 ^ nw2;

    always_comb begin
        state_nxt    = state;
        rk_valid_nxt = rk_valid;
        rk_round_nxt = rk_round;
        rk_data_nxt  = rk_data;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    rk_data_nxt  = key_in;
                    rk_round_nxt = '0;
                    rk_valid_nxt = 1'b1;
                    state_nxt    = EMIT;
                end
            end
            EMIT: begin
                if (rk_valid && rk_ready) begin
                    if (rk_round == LAST_ROUND) begin
                        rk_valid_nxt = 1'b0;
                        done_nxt     = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        rk_data_nxt  = {nw0, nw1, nw2, nw3};
                        rk_round_nxt = round_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_round  <= '0;
            rk_data   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            rk_valid  <= rk_valid_nxt;
            rk_round  <= rk_round_nxt;
            rk_data   <= rk_data_nxt;
            done      <= done_nxt;
        end
    end

`ifdef AES_KEY_STORE_EN
    logic [AES_KEY_W-1:0] store [AES_NR+1];

    // A new key wipes the previous schedule; each round key is captured as it is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < AES_NR + 1; i++) store[i] <= '0;
            rd_data <= '0;
        end else begin
            if (state == IDLE && key_valid) begin
                for (int unsigned i = 1; i < AES_NR + 1; i++) store[i] <= '0;
                store[0] <= key_in;
            end else if (state == EMIT && rk_valid && rk_ready && rk_round != LAST_ROUND) begin
                store[round_inc] <= rk_data_nxt;
            end
            rd_data <= (rd_addr <= LAST_ROUND) ? store[rd_addr] : '0;
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule
